// File: rtl/tlul_host_driver.sv
// TL-UL single-outstanding initiator: local command port -> A-channel Get/PutFullData beat,
// matching D-channel ack -> local response port, with source tagging, checking and a D timeout.
module tlul_host_driver #(
  parameter int TL_ADDR_WIDTH   = 64,
  parameter int TL_DATA_WIDTH   = 64,
  parameter int TL_SOURCE_WIDTH = 3,
  parameter int TL_SINK_WIDTH   = 3,
  parameter int TL_SIZE_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // local command port
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [TL_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [TL_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [TL_DATA_WIDTH/8-1:0]   cmd_mask,
  input  logic [TL_SIZE_WIDTH-1:0]     cmd_size,
  // local response port
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [TL_DATA_WIDTH-1:0]     rsp_rdata,
  output logic                         rsp_error,
  output logic                         rsp_timeout,
  // TL-UL A channel
  output logic                         a_valid,
  output logic [2:0]                   a_opcode,
  output logic [2:0]                   a_param,
  output logic [TL_ADDR_WIDTH-1:0]     a_address,
  output logic [TL_SIZE_WIDTH-1:0]     a_size,
  output logic [TL_DATA_WIDTH/8-1:0]   a_mask,
  output logic [TL_DATA_WIDTH-1:0]     a_data,
  output logic [TL_SOURCE_WIDTH-1:0]   a_source,
  input  logic                         a_ready,
  // TL-UL D channel
  input  logic                         d_valid,
  input  logic [2:0]                   d_opcode,
  input  logic [2:0]                   d_param,
  input  logic [TL_SIZE_WIDTH-1:0]     d_size,
  input  logic [TL_SINK_WIDTH-1:0]     d_sink,
  input  logic [TL_SOURCE_WIDTH-1:0]   d_source,
  input  logic [TL_DATA_WIDTH-1:0]     d_data,
  input  logic                         d_error,
  output logic                         d_ready
);

  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP, S_RSP} state_t;

  state_t                       r_state;
  logic                         r_write;
  logic [CNT_W-1:0]             r_cnt;
  logic [TL_SOURCE_WIDTH-1:0]   r_src_id;
  logic                         r_cmd_ready;
  logic                         r_a_valid;
  logic [2:0]                   r_a_opcode;
  logic [TL_ADDR_WIDTH-1:0]     r_a_address;
  logic [TL_SIZE_WIDTH-1:0]     r_a_size;
  logic [TL_DATA_WIDTH/8-1:0]   r_a_mask;
  logic [TL_DATA_WIDTH-1:0]     r_a_data;
  logic                         r_d_ready;
  logic                         r_rsp_valid;
  logic [TL_DATA_WIDTH-1:0]     r_rsp_rdata;
  logic                         r_rsp_error;
  logic                         r_rsp_timeout;

  logic [2:0] w_exp_d_opcode;
  logic       w_d_bad;
  logic       w_unused;

  // A write expects AccessAck, a read AccessAckData; anything else is flagged as an error.
  assign w_exp_d_opcode = r_write ? OP_ACCESS_ACK : OP_ACCESS_ACK_DATA;
  assign w_d_bad        = d_error || (d_source != r_src_id) || (d_opcode != w_exp_d_opcode);
  assign w_unused       = ^{d_param, d_size, d_sink};

  always_ff @(posedge clk) begin
    // NOTE: every state register uses <= so all updates in this block see pre-edge values.
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_write       <= 1'b0;
      r_cnt         <= '0;
      r_src_id      <= '0;
      r_cmd_ready   <= 1'b0;
      r_a_valid     <= 1'b0;
      r_a_opcode    <= '0;
      r_a_address   <= '0;
      r_a_size      <= '0;
      r_a_mask      <= '0;
      r_a_data      <= '0;
      r_d_ready     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_write     <= cmd_write;
            r_a_valid   <= 1'b1;
            r_a_opcode  <= cmd_write ? OP_PUT_FULL : OP_GET;
            r_a_address <= cmd_addr;
            r_a_size    <= cmd_size;
            r_a_mask    <= cmd_mask;
            r_a_data    <= cmd_write ? cmd_wdata : '0;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (a_ready) begin
            r_a_valid <= 1'b0;
            r_d_ready <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          r_cnt <= r_cnt + 1'b1;
          // A beat landing on the timeout cycle still wins over the timeout.
          if (d_valid) begin
            r_d_ready     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_write ? '0 : d_data;
            r_rsp_error   <= w_d_bad;
            r_rsp_timeout <= 1'b0;
            r_state       <= S_RSP;
          end else if (r_cnt == CNT_LAST) begin
            r_d_ready     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_src_id    <= r_src_id + 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign a_valid     = r_a_valid;
  assign a_opcode    = r_a_opcode;
  assign a_param     = 3'd0;
  assign a_address   = r_a_address;
  assign a_size      = r_a_size;
  assign a_mask      = r_a_mask;
  assign a_data      = r_a_data;
  assign a_source    = r_src_id;
  assign d_ready     = r_d_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_error   = r_rsp_error;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_tlul_host_driver.sv
// Directed bench for tlul_host_driver: a transaction-level model predicts each A beat and
// response; a negedge compare process checks them while valid, directed checks pin timing.
module tb_tlul_host_driver;

  localparam int AW = 64, DW = 64, SW = DW / 8, SRCW = 3, SINKW = 3, SZW = 8, TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [AW-1:0]   cmd_addr = '0;
  logic [DW-1:0]   cmd_wdata = '0;
  logic [SW-1:0]   cmd_mask = '0;
  logic [SZW-1:0]  cmd_size = '0;
  logic            rsp_valid, rsp_ready = 0, rsp_error, rsp_timeout;
  logic [DW-1:0]   rsp_rdata;
  logic            a_valid, a_ready = 0;
  logic [2:0]      a_opcode, a_param;
  logic [AW-1:0]   a_address;
  logic [SZW-1:0]  a_size;
  logic [SW-1:0]   a_mask;
  logic [DW-1:0]   a_data;
  logic [SRCW-1:0] a_source;
  logic            d_valid = 0, d_error = 0, d_ready;
  logic [2:0]      d_opcode = '0, d_param = '0;
  logic [SZW-1:0]  d_size = '0;
  logic [SINKW-1:0] d_sink = '0;
  logic [SRCW-1:0] d_source = '0;
  logic [DW-1:0]   d_data = '0;

  tlul_host_driver #(
    .TL_ADDR_WIDTH(AW), .TL_DATA_WIDTH(DW), .TL_SOURCE_WIDTH(SRCW),
    .TL_SINK_WIDTH(SINKW), .TL_SIZE_WIDTH(SZW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param), .a_address(a_address),
    .a_size(a_size), .a_mask(a_mask), .a_data(a_data), .a_source(a_source), .a_ready(a_ready),
    .d_valid(d_valid), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_sink(d_sink),
    .d_source(d_source), .d_data(d_data), .d_error(d_error), .d_ready(d_ready)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of the open transaction.
  logic            m_open = 1'b0;
  logic [SRCW-1:0] m_src = '0;
  logic [2:0]      m_a_op;
  logic [AW-1:0]   m_a_addr;
  logic [DW-1:0]   m_a_data;
  logic [SW-1:0]   m_a_mask;
  logic [SZW-1:0]  m_a_size;
  logic [DW-1:0]   m_rsp_rdata;
  logic            m_rsp_err, m_rsp_to;

  always @(negedge clk) begin
    if (rst_n && m_open) begin
      if (a_valid)
        check("a_beat", {a_opcode, a_param, a_address, a_size, a_mask, a_data, a_source},
              {m_a_op, 3'd0, m_a_addr, m_a_size, m_a_mask, m_a_data, m_src});
      if (rsp_valid)
        check("rsp_beat", {rsp_rdata, rsp_error, rsp_timeout}, {m_rsp_rdata, m_rsp_err, m_rsp_to});
      if (a_valid || d_ready || rsp_valid)
        check("cmd_ready_busy", cmd_ready, 1'b0);
    end
  end

  typedef struct {
    logic [2:0]    a_op;
    logic [2:0]    a_src;
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
    int            lat_acc;
    int            lat_hs;
  } obs_t;

  function automatic logic [255:0] all_outputs();
    return {cmd_ready, a_valid, a_opcode, a_param, a_address, a_size, a_mask, a_data, a_source,
            d_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout};
  endfunction

  // mode 0: D response one cycle after the A handshake; 1: no response; 2: reset in WAIT_RSP.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] mask, input logic [SZW-1:0] size, input int stall,
                         input int mode, input logic [2:0] dop, input logic [SRCW-1:0] dsrc,
                         input logic [DW-1:0] ddat, input logic derr, input int hold,
                         output obs_t o);
    int acc_cyc, hs_cyc, n;
    o = '{default: 0};
    m_a_op   = wr ? 3'd0 : 3'd4;
    m_a_addr = addr;
    m_a_data = wr ? wdata : '0;
    m_a_mask = mask;
    m_a_size = size;
    if (mode == 1) begin
      m_rsp_err = 1'b1; m_rsp_to = 1'b1; m_rsp_rdata = '0;
    end else begin
      m_rsp_err   = derr || (dsrc != m_src) || (dop != (wr ? 3'd0 : 3'd1));
      m_rsp_to    = 1'b0;
      m_rsp_rdata = wr ? '0 : ddat;
    end
    m_open = 1'b1;

    n = 0;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    cmd_mask = mask; cmd_size = size;
    acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = '1; cmd_wdata = '1; cmd_mask = '0; cmd_size = '1;
    check("a_valid_req", a_valid, 1'b1);
    o.a_op  = a_opcode;
    o.a_src = a_source;
    for (int i = 0; i < stall; i++) begin @(posedge clk); #1; end
    a_ready = 1'b1;
    hs_cyc  = cyc;
    @(posedge clk); #1;
    a_ready = 1'b0;
    check("wait_rsp_handshake", {a_valid, d_ready}, 2'b01);

    if (mode == 2) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort_outputs_zero", all_outputs(), '0);
      rst_n  = 1'b1;
      m_src  = '0;
      m_open = 1'b0;
    end else begin
      if (mode == 0) begin
        d_valid = 1'b1; d_opcode = dop; d_source = dsrc; d_data = ddat; d_error = derr;
        d_param = 3'd5; d_sink = 3'd6; d_size = size;
        @(posedge clk); #1;
        d_valid = 1'b0; d_error = 1'b0;
      end
      n = 0;
      while (!rsp_valid && n < 64) begin @(posedge clk); #1; n++; end
      check("rsp_valid_rise", rsp_valid, 1'b1);
      o.lat_acc = cyc - acc_cyc;
      o.lat_hs  = cyc - hs_cyc;
      o.rdata   = rsp_rdata;
      o.err     = rsp_error;
      o.to      = rsp_timeout;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("rsp_hold", rsp_valid, 1'b1);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("rsp_release", {rsp_valid, d_ready}, 2'b00);
      m_src  = m_src + 1'b1;
      m_open = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  initial begin
    obs_t o;
    logic [2:0] wrap_seq [9];
    wrap_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", all_outputs(), '0);
    rst_n = 1'b1;

    // Write, zero stall, AccessAck from source 0; ack data must not leak into rdata.
    run_txn(1'b1, 64'h1000, 64'hDEADBEEF_CAFEF00D, 8'hFF, 8'd3, 0, 0,
            3'd0, 3'd0, 64'h1111_2222_3333_4444, 1'b0, 0, o);
    check("t1_opcode", o.a_op, 3'd0);
    check("t1_src", o.a_src, 3'd0);
    check("t1_latency", o.lat_acc, 3);
    check("t1_rsp", {o.rdata, o.err, o.to}, '0);

    // Read with a 4-cycle A stall.
    run_txn(1'b0, 64'h2000, 64'h5555_5555_5555_5555, 8'hFF, 8'd3, 4, 0,
            3'd1, 3'd1, 64'h0123456789ABCDEF, 1'b0, 0, o);
    check("t2_opcode", o.a_op, 3'd4);
    check("t2_rdata", o.rdata, 64'h0123456789ABCDEF);
    check("t2_err", {o.err, o.to}, 2'b00);
    check("t2_hs_latency", o.lat_hs, 2);

    // Reset while waiting on D: outputs drop, source id restarts at 0.
    run_txn(1'b0, 64'h3000, '0, 8'hFF, 8'd3, 0, 2, 3'd1, 3'd2, '0, 1'b0, 0, o);

    // Nine back-to-back reads: source wraps 0..7,0; last response held 5 cycles.
    for (int i = 0; i < 9; i++) begin
      run_txn(1'b0, 64'h4000 + 64'(i * 8), '0, 8'h0F, 8'd2, i % 2, 0,
              3'd1, m_src, 64'hA5A5_0000_0000_0000 + 64'(i), 1'b0, (i == 8) ? 5 : 0, o);
      check("wrap_src", o.a_src, wrap_seq[i]);
    end

    // d_error on a read (src 1).
    run_txn(1'b0, 64'h5000, '0, 8'hFF, 8'd3, 0, 0, 3'd1, 3'd1, 64'hAAAA, 1'b1, 0, o);
    check("t5_err", {o.err, o.to}, 2'b10);

    // Source mismatch (src 2, D says 3).
    run_txn(1'b0, 64'h6000, '0, 8'hFF, 8'd3, 0, 0, 3'd1, 3'd3, 64'hBBBB, 1'b0, 0, o);
    check("t6_err", {o.err, o.to}, 2'b10);

    // No D response: forced error 16 cycles after the A handshake.
    run_txn(1'b0, 64'h7000, '0, 8'hFF, 8'd3, 0, 1, 3'd0, 3'd0, '0, 1'b0, 0, o);
    check("t7_timeout_latency", o.lat_hs, 16);
    check("t7_timeout_rsp", {o.rdata, o.err, o.to}, {64'h0, 1'b1, 1'b1});

    // Write answered with AccessAckData: opcode mismatch (src 4).
    run_txn(1'b1, 64'h8000, 64'h0F0F, 8'h03, 8'd1, 1, 0, 3'd1, 3'd4, 64'hCCCC, 1'b0, 0, o);
    check("t8_opcode_err", {o.rdata, o.err, o.to}, {64'h0, 1'b1, 1'b0});

    // Clean read after the error cases (src 5).
    run_txn(1'b0, 64'h9000, '0, 8'hFF, 8'd3, 2, 0, 3'd1, 3'd5, 64'hFEED_FACE, 1'b0, 1, o);
    check("t9_clean", {o.rdata, o.err, o.to, o.a_src}, {64'hFEED_FACE, 1'b0, 1'b0, 3'd5});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
